// File: rtl/cache_fill_ctrl_pkg.sv
// ============================================================================
// Module   : cache_fill_pkg
// Purpose  : Shared types and constants for the cache miss-fill controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fill_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_W       = 3;
    localparam int INDEX_W        = 6;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage : cache_fill_pkg

`default_nettype wire

// File: rtl/cache_fill_ctrl_arbiter.sv
// ============================================================================
// Module   : fill_arbiter
// Purpose  : Picks the I- or D-cache requester for the next line fill.
//            FILL_RR_ARB_EN selects round-robin tie breaking, else D wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_arbiter
    import cache_fill_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_miss,
    input  logic d_miss,
    input  logic grant_en,
    output logic gnt_sel
);

`ifdef FILL_RR_ARB_EN
    // Remembers the winner of the most recent tie; reset value lets D win first.
    logic last_tie_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_tie_q <= REQ_I;
        end else if (grant_en && i_miss && d_miss) begin
            last_tie_q <= gnt_sel;
        end
    end

    always_comb begin
        gnt_sel = REQ_I;
        if (i_miss && d_miss) begin
            gnt_sel = ~last_tie_q;
        end else if (d_miss) begin
            gnt_sel = REQ_D;
        end
    end
`else
    logic unused_arb_inputs;
    assign unused_arb_inputs = ^{clk, rst_n, grant_en, i_miss};

    always_comb begin
        gnt_sel = d_miss ? REQ_D : REQ_I;
    end
`endif

endmodule : fill_arbiter

`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
// ============================================================================
// Module   : cache_fill_ctrl
// Purpose  : Arbitrates I/D cache misses and sequences an 8-word line refill
//            from pipelined memory. Optional macro: FILL_RR_ARB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = cache_fill_pkg::WORDS_PER_LINE,
    parameter int INDEX_W        = cache_fill_pkg::INDEX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_miss,
    input  logic [ADDR_W-1:0]   i_miss_addr,
    input  logic                d_miss,
    input  logic [ADDR_W-1:0]   d_miss_addr,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_data_valid,
    input  logic [15:0]         mem_data_in,
    output logic                fill_we,
    output logic [15:0]         fill_data,
    output logic [OFFSET_W-1:0] fill_word,
    output logic [INDEX_W-1:0]  fill_index,
    output logic                fill_tag_we,
    output logic                fill_sel,
    output logic                i_fill_done,
    output logic                d_fill_done,
    output logic                busy
);

    localparam int CNT_W   = $clog2(WORDS_PER_LINE + 1);
    localparam int LINE_SH = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);

    fill_state_e       state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] req_addr;
    logic              sel_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  ret_cnt_q;
    logic              tag_we_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              gnt_sel;
    logic              in_fill;
    logic              issuing;

    fill_arbiter u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_miss   (i_miss),
        .d_miss   (d_miss),
        .grant_en (state_q == ST_IDLE),
        .gnt_sel  (gnt_sel)
    );

    assign req_addr = (gnt_sel == REQ_D) ? d_miss_addr : i_miss_addr;
    assign base_d   = {req_addr[ADDR_W-1:LINE_SH], {LINE_SH{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            sel_q       <= REQ_I;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            tag_we_q    <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            tag_we_q <= 1'b0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_miss || d_miss) begin
                        sel_q       <= gnt_sel;
                        base_q      <= base_d;
                        issue_cnt_q <= '0;
                        ret_cnt_q   <= '0;
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (issue_cnt_q < LINE_WORDS) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    // Tag write and done pulse are raised as the last word lands.
                    if (mem_data_valid) begin
                        ret_cnt_q <= ret_cnt_q + 1'b1;
                        if (ret_cnt_q == LAST_WORD) begin
                            state_q  <= ST_DONE;
                            tag_we_q <= 1'b1;
                            i_done_q <= (sel_q == REQ_I);
                            d_done_q <= (sel_q == REQ_D);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_fill = (state_q == ST_FILL);
    assign issuing = in_fill && (issue_cnt_q < LINE_WORDS);

    assign mem_en      = issuing;
    assign mem_addr    = issuing ? (base_q + ADDR_W'({issue_cnt_q, 1'b0})) : '0;
    assign fill_we     = in_fill && mem_data_valid;
    assign fill_data   = in_fill ? mem_data_in : 16'h0000;
    assign fill_word   = ret_cnt_q[OFFSET_W-1:0];
    assign fill_index  = base_q[LINE_SH +: INDEX_W];
    assign fill_sel    = sel_q;
    assign fill_tag_we = tag_we_q;
    assign i_fill_done = i_done_q;
    assign d_fill_done = d_done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule : cache_fill_ctrl

`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
// ============================================================================
// Module   : tb_cache_fill_ctrl
// Purpose  : Self-checking bench for cache_fill_ctrl with a 4-cycle memory
//            model and a line-fill reference model. Honours FILL_RR_ARB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0;
    logic [15:0] i_miss_addr = 16'h0;
    logic        d_miss = 1'b0;
    logic [15:0] d_miss_addr = 16'h0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        fill_we;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic [5:0]  fill_index;
    logic        fill_tag_we;
    logic        fill_sel;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        busy;

    logic        stray_v = 1'b0;
    logic [15:0] stray_d = 16'h0;
    logic [15:0] salt = 16'h0;
    logic [3:0]        pv;
    logic [3:0][15:0]  pa;
    logic        m_last_tie = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    wire [47:0] obs = {busy, mem_en, mem_addr, fill_we, fill_word, fill_index,
                       fill_sel, fill_tag_we, i_fill_done, d_fill_done, fill_data};

    cache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .fill_we        (fill_we),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .fill_index     (fill_index),
        .fill_tag_we    (fill_tag_we),
        .fill_sel       (fill_sel),
        .i_fill_done    (i_fill_done),
        .d_fill_done    (d_fill_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a, input logic [15:0] s);
        return {a[7:0], a[15:8]} ^ s;
    endfunction

    // Memory: a request sampled at the end of cycle T returns in cycle T+4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pa <= '0;
        end else begin
            pv <= {pv[2:0], mem_en};
            pa <= {pa[2:0], mem_addr};
        end
    end

    assign mem_data_valid = pv[3] | stray_v;
    assign mem_data_in    = pv[3] ? memf(pa[3], salt) : stray_d;

    task automatic predict_first(input logic i, input logic d, output logic first);
        if (i && d) begin
`ifdef FILL_RR_ARB_EN
            first = ~m_last_tie;
`else
            first = 1'b1;
`endif
            m_last_tie = first;
        end else begin
            first = d;
        end
    endtask

    // Follows one fill from T1 to T14, comparing every output each cycle.
    task automatic observe_fill(input logic sel, input logic [15:0] addr,
                                input int max_wait, input int drop_at, input string name);
        logic [15:0] base;
        logic [47:0] exp;
        logic        e_en, e_we;
        logic [15:0] e_addr, e_data;
        logic [2:0]  e_word;
        int          w;
        base = addr & 16'hFFF0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < max_wait);
        n_checks++;
        if (!busy) begin
            $display("FAIL %s grant: busy=%b after %0d cycles, required 1", name, busy, w);
            return;
        end
        n_pass++;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            e_en   = (k <= 8);
            e_addr = e_en ? base + 16'(2 * (k - 1)) : 16'h0;
            e_we   = (k >= 5) && (k <= 12);
            e_word = e_we ? 3'(k - 5) : 3'd0;
            e_data = e_we ? memf(base + 16'(2 * (k - 5)), salt) : 16'h0;
            exp = {(k <= 13), e_en, e_addr, e_we, e_word, base[9:4], sel,
                   (k == 13), (k == 13) && !sel, (k == 13) && sel, e_data};
            n_checks++;
            if (obs !== exp)
                $display("FAIL %s T%0d: got %h, required %h", name, k, obs, exp);
            else
                n_pass++;
            if (k == drop_at || k == 13) begin
                if (sel) d_miss = 1'b0;
                else     i_miss = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 48'h0) $display("FAIL reset_state: got %h, required 0", obs);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_d();
        logic first;
        salt = 16'h3C5A;
        d_miss_addr = 16'h1A36;
        d_miss = 1'b1;
        predict_first(1'b0, 1'b1, first);
        observe_fill(first, 16'h1A36, 1, 0, "single_d");
    endtask

    task automatic test_tie();
        logic first;
        for (int r = 0; r < 2; r++) begin
            i_miss_addr = 16'h0120 + 16'(r * 16'h0400);
            d_miss_addr = 16'h0F5E + 16'(r * 16'h0400);
            i_miss = 1'b1;
            d_miss = 1'b1;
            predict_first(1'b1, 1'b1, first);
            observe_fill(first, first ? d_miss_addr : i_miss_addr, 1, 0, "tie_first");
            observe_fill(~first, first ? i_miss_addr : d_miss_addr, 1, 0, "tie_second");
        end
    endtask

    task automatic test_stray();
        logic first;
        stray_v = 1'b1;
        stray_d = 16'hBEEF;
        #1;
        n_checks++;
        if ({busy, fill_we, fill_data} !== 18'h0)
            $display("FAIL stray_idle: got %h, required 0", {busy, fill_we, fill_data});
        else
            n_pass++;
        @(negedge clk);
        stray_v = 1'b0;
        stray_d = 16'h0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stray_busy: got %b, required 0", busy);
        else n_pass++;
        i_miss_addr = 16'h7770;
        i_miss = 1'b1;
        predict_first(1'b1, 1'b0, first);
        observe_fill(first, 16'h7770, 1, 0, "after_stray");
    endtask

    task automatic test_reset_midfill();
        logic first;
        d_miss_addr = 16'h2222;
        d_miss = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        d_miss = 1'b0;
        m_last_tie = 1'b0;
        #1;
        n_checks++;
        if (obs !== 48'h0) $display("FAIL reset_midfill: got %h, required 0", obs);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_miss_addr = 16'h0040;
        i_miss = 1'b1;
        predict_first(1'b1, 1'b0, first);
        observe_fill(first, 16'h0040, 1, 0, "post_reset_i");
    endtask

    task automatic test_miss_drop();
        d_miss_addr = 16'hC0DE;
        d_miss = 1'b1;
        observe_fill(1'b1, 16'hC0DE, 1, 3, "miss_drop");
    endtask

    task automatic test_random();
        logic first;
        int   mode;
        for (int it = 0; it < 8; it++) begin
            salt = 16'($urandom);
            i_miss_addr = 16'($urandom);
            d_miss_addr = 16'($urandom);
            mode = $urandom_range(0, 2);
            i_miss = (mode != 1);
            d_miss = (mode != 0);
            predict_first(i_miss, d_miss, first);
            observe_fill(first, first ? d_miss_addr : i_miss_addr, 1, 0, "rand_first");
            if (mode == 2)
                observe_fill(~first, first ? i_miss_addr : d_miss_addr, 1, 0, "rand_second");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_d();
        test_tie();
        test_stray();
        test_reset_midfill();
        test_miss_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cache_fill_ctrl

`default_nettype wire

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-fill controller for the phase-3 cache subsystem. It arbitrates between instruction-cache and data-cache miss requests and sequences an 8-word line refill from the 4-cycle pipelined main memory. For each returned word it drives the data-array write strobe, the word offset and the 6-bit line index; the index feeds the existing 6-to-64 one-hot line decoder. It finishes each fill with a tag/valid write and a done pulse to the granted cache.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- WORDS_PER_LINE, 8, 16-bit words per line (fixed at 8 in this release)
- INDEX_W, 6, line-index width (64 lines)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache miss, held until i_fill_done
- i_miss_addr  in  16  I-cache miss address
- d_miss  in  1  D-cache miss, held until d_fill_done
- d_miss_addr  in  16  D-cache miss address
- mem_en  out  1  memory read request
- mem_addr  out  16  memory read address (word-aligned)
- mem_data_valid  in  1  memory return strobe; returns arrive in request order
- mem_data_in  in  16  memory return data
- fill_we  out  1  data-array write strobe
- fill_data  out  16  data to write
- fill_word  out  3  word offset within the line
- fill_index  out  6  line index, i.e. granted address bits [9:4]
- fill_tag_we  out  1  tag/valid write strobe
- fill_sel  out  1  granted requester, 0 = I-cache, 1 = D-cache
- i_fill_done  out  1  one-cycle pulse at I-fill completion
- d_fill_done  out  1  one-cycle pulse at D-fill completion
- busy  out  1  high whenever the controller is not in IDLE

## Operation
- FSM states: IDLE, FILL, DONE.
- **IDLE.** If any miss is high, grant one requester per the arbitration rule. Register fill_sel and base = addr & 16'hFFF0, clear both counters, then go to FILL.
- **FILL, issue side.** The issue counter (0..8) drives mem_en = 1 with mem_addr = base + 2·issue_cnt while issue_cnt < 8, incrementing each cycle. Issue is unconditional; memory never stalls.
- **FILL, return side.** The return counter (0..8) drives fill_we = mem_data_valid, fill_data = mem_data_in (combinational pass-through) and fill_word = ret_cnt[2:0]. ret_cnt increments on each valid return.
- **FILL exit.** On the 8th valid return, go to DONE.
- **DONE (one cycle).** fill_tag_we = 1, and the done pulse for fill_sel fires. Then go to IDLE.
- **Hold rules.** fill_index and fill_sel hold from grant until IDLE is re-entered. fill_index equals base[9:4].
- **Ignored inputs.** mem_data_valid in IDLE or DONE is ignored. A miss deasserting mid-fill does not abort the fill; the line still completes.
- **Arbitration, default.** Fixed priority, D-cache over I-cache.
- **Reset.** Reset mid-fill returns the FSM to IDLE and clears the counters. Outstanding memory returns are the memory's responsibility, since memory shares rst_n.

## Timing
- **Reset values.** All outputs 0: mem_en, mem_addr, fill_we, fill_data (mem_data_in is gated by FILL), fill_word, fill_index, fill_tag_we, fill_sel, both done pulses, busy. The round-robin pointer resets to favour D.
- **Example fill, grant sampled in IDLE at cycle T0.** FILL runs from T1. mem_en is high T1..T8 with addresses base+0 through base+14. With 4-cycle memory, returns arrive T5..T12, the FSM is in DONE at T13, and IDLE at T14.
- **Back-to-back fills.** Minimum issue-to-issue spacing between fills is 14 cycles. A miss pending in the T14 IDLE cycle is granted that cycle, with its first mem_en at T15.
- **busy.** High T1..T13.
- **Simultaneous misses.** Only one grant is made. The loser stays pending and is granted in the first IDLE cycle after DONE.

## Configuration
- Macro: FILL_RR_ARB_EN.
- **Defined.** Round-robin arbitration. A 1-bit pointer records the last-granted requester. On simultaneous misses the other requester wins. After reset the pointer state makes D win the first tie.
- **Undefined.** Fixed priority, D over I. No pointer flop exists.

## Structure
- **Package cache_fill_pkg:** state enum (IDLE/FILL/DONE), WORDS_PER_LINE, OFFSET_W = 3, INDEX_W = 6, REQ_I = 1'b0, REQ_D = 1'b1.
- **Sub-module fill_arbiter:** inputs i_miss, d_miss, grant_en, clk, rst_n; output gnt_sel. It contains the optional round-robin pointer under FILL_RR_ARB_EN.

## Test plan
- **Single D-miss.** d_miss = 1, d_miss_addr = 16'h1A36, 4-cycle memory.
  - mem_addr sequence is 1A30, 1A32, …, 1A3E.
  - fill_index = 6'h23 and fill_word steps 0..7 with fill_we.
  - fill_tag_we and d_fill_done pulse at T13; busy spans T1..T13.
- **Simultaneous misses, macro undefined.** i_miss and d_miss both high in the same cycle.
  - D is served first (fill_sel = 1), then I, with the I grant in the IDLE cycle following D's DONE.
- **Simultaneous misses twice, FILL_RR_ARB_EN defined.** Grant order is D, I, then I, D on the second tie.
- **Stray return.** mem_data_valid = 1 while IDLE → fill_we stays 0 and ret_cnt stays 0.
- **Reset mid-fill.** rst_n low at T6 → all outputs 0 immediately; after release, a new I-miss at 16'h0040 fills correctly from base 0040.
- **Miss dropped.** d_miss deasserted at T3 → all 8 words are still written, followed by d_fill_done.
